// File: rtl/msf_frame_decoder.sv
// MSF 60-second frame assembler: captures A/B bits by second index, validates
// parity, marker pattern and BCD ranges, and emits a one-cycle load at the next minute marker.
module msf_frame_decoder #(
    parameter bit CHECK_RANGE    = 1'b1,
    parameter bit REQUIRE_MARKER = 1'b1
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       sym_valid_i,
    input  logic       sym_marker_i,
    input  logic       sym_a_i,
    input  logic       sym_b_i,
    output logic       load_o,
    output logic [3:0] year_h_o,
    output logic [3:0] year_l_o,
    output logic       month_h_o,
    output logic [3:0] month_l_o,
    output logic [1:0] day_h_o,
    output logic [3:0] day_l_o,
    output logic [1:0] hour_h_o,
    output logic [3:0] hour_l_o,
    output logic [2:0] minute_h_o,
    output logic [3:0] minute_l_o,
    output logic [2:0] second_h_o,
    output logic [3:0] second_l_o,
    output logic       bst_o,
    output logic       locked_o,
    output logic       frame_err_o
);

    typedef enum logic {HUNT, RECV} state_t;

    state_t     state, state_nxt;
    logic [5:0] sec_cnt, sec_cnt_nxt;
    logic [5:0] idx;
    logic       mark_sym, data_sym;
    logic       accept, reject, clear, capture;

    logic [7:0] year_sr;
    logic [4:0] month_sr;
    logic [5:0] day_sr;
    logic [5:0] hour_sr;
    logic [6:0] minute_sr;
    logic [7:0] marker_sr;
    logic       bst_sr;
    logic       p_year, p_date, p_wday, p_time;

    logic parity_ok, marker_ok, range_ok, checks_ok;
    logic digits_ok, month_ok, day_ok, hour_ok, minute_ok;

    assign mark_sym = sym_valid_i & sym_marker_i;
    assign data_sym = sym_valid_i & ~sym_marker_i;
    assign idx      = sec_cnt + 6'd1;

    // Odd parity: each accumulator XORs its A bits with the B parity bit, so 1 means pass.
    assign parity_ok = p_year & p_date & p_wday & p_time;
    assign marker_ok = !REQUIRE_MARKER || (marker_sr == 8'b0111_1110);

    assign digits_ok = (year_sr[7:4] <= 4'd9) && (year_sr[3:0] <= 4'd9) &&
                       (month_sr[3:0] <= 4'd9) && (day_sr[3:0] <= 4'd9) &&
                       (hour_sr[3:0] <= 4'd9) && (minute_sr[3:0] <= 4'd9);
    assign month_ok  = month_sr[4] ? (month_sr[3:0] <= 4'd2) : (month_sr[3:0] != 4'd0);
    assign day_ok    = (day_sr[5:4] == 2'd0) ? (day_sr[3:0] != 4'd0) :
                       (day_sr[5:4] == 2'd3) ? (day_sr[3:0] <= 4'd1) : 1'b1;
    assign hour_ok   = (hour_sr[5:4] == 2'd2) ? (hour_sr[3:0] <= 4'd3) : (hour_sr[5:4] != 2'd3);
    assign minute_ok = (minute_sr[6:4] <= 3'd5);
    assign range_ok  = digits_ok && month_ok && day_ok && hour_ok && minute_ok;

    assign checks_ok = parity_ok && marker_ok && (!CHECK_RANGE || range_ok);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= HUNT;
            sec_cnt <= 6'd0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state   <= state_nxt;
            sec_cnt <= sec_cnt_nxt;
        end
    end

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        state_nxt   = state;
        sec_cnt_nxt = sec_cnt;
        accept      = 1'b0;
        reject      = 1'b0;
        clear       = 1'b0;
        capture     = 1'b0;
        case (state)
            HUNT: begin
                if (mark_sym) begin
                    state_nxt   = RECV;
                    sec_cnt_nxt = 6'd0;
                    clear       = 1'b1;
                end
            end
            RECV: begin
                if (mark_sym) begin
                    sec_cnt_nxt = 6'd0;
                    clear       = 1'b1;
                    if (sec_cnt == 6'd59 && checks_ok) accept = 1'b1;
                    else                               reject = 1'b1;
                end else if (data_sym) begin
                    if (sec_cnt == 6'd59) begin
                        reject      = 1'b1;
                        state_nxt   = HUNT;
                        sec_cnt_nxt = 6'd0;
                    end else begin
                        sec_cnt_nxt = idx;
                        capture     = 1'b1;
                    end
                end
            end
            default: state_nxt = HUNT;
        endcase
    end

    // Fields shift in MSB first; a full 59-second frame overwrites every one of them.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            year_sr   <= '0;
            month_sr  <= '0;
            day_sr    <= '0;
            hour_sr   <= '0;
            minute_sr <= '0;
            marker_sr <= '0;
            bst_sr    <= 1'b0;
            p_year    <= 1'b0;
            p_date    <= 1'b0;
            p_wday    <= 1'b0;
            p_time    <= 1'b0;
        end else if (clear) begin
            p_year <= 1'b0;
            p_date <= 1'b0;
            p_wday <= 1'b0;
            p_time <= 1'b0;
        end else if (capture) begin
            if (idx inside {[6'd17:6'd24]}) begin
                year_sr <= {year_sr[6:0], sym_a_i};
                p_year  <= p_year ^ sym_a_i;
            end
            if (idx inside {[6'd25:6'd29]}) month_sr <= {month_sr[3:0], sym_a_i};
            if (idx inside {[6'd30:6'd35]}) day_sr   <= {day_sr[4:0], sym_a_i};
            if (idx inside {[6'd25:6'd35]}) p_date   <= p_date ^ sym_a_i;
            if (idx inside {[6'd36:6'd38]}) p_wday   <= p_wday ^ sym_a_i;
            if (idx inside {[6'd39:6'd44]}) hour_sr  <= {hour_sr[4:0], sym_a_i};
            if (idx inside {[6'd45:6'd51]}) minute_sr <= {minute_sr[5:0], sym_a_i};
            if (idx inside {[6'd39:6'd51]}) p_time   <= p_time ^ sym_a_i;
            if (idx inside {[6'd52:6'd59]}) marker_sr <= {marker_sr[6:0], sym_a_i};
            if (idx == 6'd54) p_year <= p_year ^ sym_b_i;
            if (idx == 6'd55) p_date <= p_date ^ sym_b_i;
            if (idx == 6'd56) p_wday <= p_wday ^ sym_b_i;
            if (idx == 6'd57) p_time <= p_time ^ sym_b_i;
            if (idx == 6'd58) bst_sr <= sym_b_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            load_o      <= 1'b0;
            frame_err_o <= 1'b0;
            year_h_o    <= '0;
            year_l_o    <= '0;
            month_h_o   <= 1'b0;
            month_l_o   <= '0;
            day_h_o     <= '0;
            day_l_o     <= '0;
            hour_h_o    <= '0;
            hour_l_o    <= '0;
            minute_h_o  <= '0;
            minute_l_o  <= '0;
            bst_o       <= 1'b0;
            locked_o    <= 1'b0;
        end else begin
            load_o      <= accept;
            frame_err_o <= reject;
            if (accept) begin
                year_h_o   <= year_sr[7:4];
                year_l_o   <= year_sr[3:0];
                month_h_o  <= month_sr[4];
                month_l_o  <= month_sr[3:0];
                day_h_o    <= day_sr[5:4];
                day_l_o    <= day_sr[3:0];
                hour_h_o   <= hour_sr[5:4];
                hour_l_o   <= hour_sr[3:0];
                minute_h_o <= minute_sr[6:4];
                minute_l_o <= minute_sr[3:0];
                bst_o      <= bst_sr;
                locked_o   <= 1'b1;
            end else if (reject) begin
                locked_o <= 1'b0;
            end
        end
    end

    assign second_h_o = 3'd0;
    assign second_l_o = 4'd0;

endmodule

// File: tb/tb_msf_frame_decoder.sv
// Directed bench for msf_frame_decoder: hand-built MSF frames with known BCD fields,
// one default instance and one with range checking disabled.
module tb_msf_frame_decoder;

    logic clk, rst_ni;
    logic sym_valid, sym_marker, sym_a, sym_b;

    logic       load_o, frame_err_o, bst_o, locked_o;
    logic [3:0] year_h, year_l, month_l, day_l, hour_l, minute_l, second_l;
    logic       month_h;
    logic [1:0] day_h, hour_h;
    logic [2:0] minute_h, second_h;

    logic       nr_load, nr_err, nr_bst, nr_locked;
    logic [3:0] nr_year_h, nr_year_l, nr_month_l, nr_day_l, nr_hour_l, nr_minute_l, nr_second_l;
    logic       nr_month_h;
    logic [1:0] nr_day_h, nr_hour_h;
    logic [2:0] nr_minute_h, nr_second_h;

    int total = 0;
    int bad   = 0;
    int load_cnt = 0, err_cnt = 0, both_cnt = 0, nr_load_cnt = 0, nr_err_cnt = 0;
    int ml, me, nml, nme;

    logic [59:0] fa, fb;

    msf_frame_decoder dut (
        .clk_i(clk), .rst_ni(rst_ni), .sym_valid_i(sym_valid), .sym_marker_i(sym_marker),
        .sym_a_i(sym_a), .sym_b_i(sym_b), .load_o(load_o),
        .year_h_o(year_h), .year_l_o(year_l), .month_h_o(month_h), .month_l_o(month_l),
        .day_h_o(day_h), .day_l_o(day_l), .hour_h_o(hour_h), .hour_l_o(hour_l),
        .minute_h_o(minute_h), .minute_l_o(minute_l), .second_h_o(second_h), .second_l_o(second_l),
        .bst_o(bst_o), .locked_o(locked_o), .frame_err_o(frame_err_o)
    );

    msf_frame_decoder #(.CHECK_RANGE(1'b0)) dut_nr (
        .clk_i(clk), .rst_ni(rst_ni), .sym_valid_i(sym_valid), .sym_marker_i(sym_marker),
        .sym_a_i(sym_a), .sym_b_i(sym_b), .load_o(nr_load),
        .year_h_o(nr_year_h), .year_l_o(nr_year_l), .month_h_o(nr_month_h), .month_l_o(nr_month_l),
        .day_h_o(nr_day_h), .day_l_o(nr_day_l), .hour_h_o(nr_hour_h), .hour_l_o(nr_hour_l),
        .minute_h_o(nr_minute_h), .minute_l_o(nr_minute_l), .second_h_o(nr_second_h),
        .second_l_o(nr_second_l), .bst_o(nr_bst), .locked_o(nr_locked), .frame_err_o(nr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (load_o)                load_cnt++;
        if (frame_err_o)           err_cnt++;
        if (load_o && frame_err_o) both_cnt++;
        if (nr_load)               nr_load_cnt++;
        if (nr_err)                nr_err_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_sym(logic m, logic a, logic b);
        sym_valid = 1'b1; sym_marker = m; sym_a = a; sym_b = b;
        @(posedge clk); #1;
        sym_valid = 1'b0; sym_marker = 1'b0; sym_a = 1'b0; sym_b = 1'b0;
    endtask

    task automatic send_data(int from, int to);
        for (int s = from; s <= to; s++) send_sym(1'b0, fa[s], fb[s]);
    endtask

    task automatic mark();
        ml = load_cnt; me = err_cnt; nml = nr_load_cnt; nme = nr_err_cnt;
    endtask

    // Builds fa/fb for one frame; parity bits make each group odd.
    task automatic build(logic [7:0] yr, logic [4:0] mo, logic [5:0] dy, logic [2:0] wd,
                         logic [5:0] hr, logic [6:0] mn, logic bst);
        logic [7:0] mk;
        mk = 8'b0111_1110;
        fa = '0; fb = '0;
        for (int i = 0; i < 8; i++) fa[17+i] = yr[7-i];
        for (int i = 0; i < 5; i++) fa[25+i] = mo[4-i];
        for (int i = 0; i < 6; i++) fa[30+i] = dy[5-i];
        for (int i = 0; i < 3; i++) fa[36+i] = wd[2-i];
        for (int i = 0; i < 6; i++) fa[39+i] = hr[5-i];
        for (int i = 0; i < 7; i++) fa[45+i] = mn[6-i];
        for (int i = 0; i < 8; i++) fa[52+i] = mk[7-i];
        fb[54] = ~(^fa[24:17]);
        fb[55] = ~(^fa[35:25]);
        fb[56] = ~(^fa[38:36]);
        fb[57] = ~(^fa[51:39]);
        fb[58] = bst;
    endtask

    task automatic end_frame(string tag, logic el, logic ee, logic nl, logic ne);
        send_sym(1'b1, 1'b0, 1'b0);
        check({tag, ".load"}, load_o, el);
        check({tag, ".err"}, frame_err_o, ee);
        check({tag, ".nr_load"}, nr_load, nl);
        check({tag, ".nr_err"}, nr_err, ne);
        @(posedge clk); #1;
        check({tag, ".load_drop"}, load_o, 1'b0);
        check({tag, ".err_drop"}, frame_err_o, 1'b0);
        check({tag, ".load_cnt"}, load_cnt - ml, el);
        check({tag, ".err_cnt"}, err_cnt - me, ee);
        check({tag, ".nr_load_cnt"}, nr_load_cnt - nml, nl);
        check({tag, ".nr_err_cnt"}, nr_err_cnt - nme, ne);
    endtask

    task automatic check_fields(string tag, logic [7:0] yr, logic [4:0] mo, logic [5:0] dy,
                                logic [5:0] hr, logic [6:0] mn, logic bst, logic lk);
        check({tag, ".year"}, {year_h, year_l}, yr);
        check({tag, ".month"}, {month_h, month_l}, mo);
        check({tag, ".day"}, {day_h, day_l}, dy);
        check({tag, ".hour"}, {hour_h, hour_l}, hr);
        check({tag, ".minute"}, {minute_h, minute_l}, mn);
        check({tag, ".second"}, {second_h, second_l}, 7'h00);
        check({tag, ".bst"}, bst_o, bst);
        check({tag, ".locked"}, locked_o, lk);
    endtask

    initial begin
        rst_ni = 1'b0;
        sym_valid = 1'b0; sym_marker = 1'b0; sym_a = 1'b0; sym_b = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.load", load_o, 1'b0);
        check("rst.err", frame_err_o, 1'b0);
        check_fields("rst", 8'h00, 5'h00, 6'h00, 6'h00, 7'h00, 1'b0, 1'b0);
        rst_ni = 1'b1;
        @(posedge clk); #1;

        // Valid frame 23-06-15 14:37 BST, preceded by a resync marker.
        mark();
        send_sym(1'b1, 1'b0, 1'b0);
        build(8'h23, 5'h06, 6'h15, 3'd4, 6'h14, 7'h37, 1'b1);
        send_data(1, 59);
        end_frame("f1", 1'b1, 1'b0, 1'b1, 1'b0);
        check_fields("f1", 8'h23, 5'h06, 6'h15, 6'h14, 7'h37, 1'b1, 1'b1);

        // Same frame with B57 inverted: parity error, fields hold.
        mark();
        fb[57] = ~fb[57];
        send_data(1, 59);
        end_frame("par", 1'b0, 1'b1, 1'b0, 1'b1);
        check_fields("par", 8'h23, 5'h06, 6'h15, 6'h14, 7'h37, 1'b1, 1'b0);

        // Short frame (40 symbols), then a valid 99-12-31 23:59 frame.
        build(8'h99, 5'h12, 6'h31, 3'd5, 6'h23, 7'h59, 1'b0);
        mark();
        send_data(1, 40);
        end_frame("short", 1'b0, 1'b1, 1'b0, 1'b1);
        mark();
        send_data(1, 59);
        end_frame("f2", 1'b1, 1'b0, 1'b1, 1'b0);
        check_fields("f2", 8'h99, 5'h12, 6'h31, 6'h23, 7'h59, 1'b0, 1'b1);

        // Month 13 with good parity: rejected only when range checks are enabled.
        build(8'h23, 5'h13, 6'h15, 3'd4, 6'h14, 7'h37, 1'b0);
        mark();
        send_data(1, 59);
        end_frame("m13", 1'b0, 1'b1, 1'b1, 1'b0);
        check_fields("m13", 8'h99, 5'h12, 6'h31, 6'h23, 7'h59, 1'b0, 1'b0);
        check("m13.nr_month", {nr_month_h, nr_month_l}, 5'h13);
        check("m13.nr_locked", nr_locked, 1'b1);

        // 60 data symbols: error on the 60th, then HUNT ignores data until a marker.
        build(8'h23, 5'h06, 6'h15, 3'd4, 6'h14, 7'h37, 1'b1);
        mark();
        send_data(1, 59);
        send_sym(1'b0, 1'b1, 1'b0);
        check("long.err", frame_err_o, 1'b1);
        check("long.load", load_o, 1'b0);
        send_data(1, 5);
        send_sym(1'b1, 1'b0, 1'b0);
        check("hunt.err", frame_err_o, 1'b0);
        check("hunt.load", load_o, 1'b0);
        @(posedge clk); #1;
        check("long.err_cnt", err_cnt - me, 1);
        check("long.load_cnt", load_cnt - ml, 0);
        check("long.nr_err_cnt", nr_err_cnt - nme, 1);
        check("long.locked", locked_o, 1'b0);
        mark();
        send_data(1, 59);
        end_frame("resync", 1'b1, 1'b0, 1'b1, 1'b0);
        check_fields("resync", 8'h23, 5'h06, 6'h15, 6'h14, 7'h37, 1'b1, 1'b1);

        // Reset at second 30: partial frame discarded, outputs cleared.
        build(8'h99, 5'h12, 6'h31, 3'd5, 6'h23, 7'h59, 1'b0);
        mark();
        send_data(1, 30);
        rst_ni = 1'b0;
        #1;
        check_fields("inrst", 8'h00, 5'h00, 6'h00, 6'h00, 7'h00, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("inrst.load", load_o, 1'b0);
        check("inrst.err", frame_err_o, 1'b0);
        rst_ni = 1'b1;
        send_data(31, 59);
        end_frame("postrst", 1'b0, 1'b0, 1'b0, 1'b0);
        check_fields("postrst", 8'h00, 5'h00, 6'h00, 6'h00, 7'h00, 1'b0, 1'b0);
        mark();
        send_data(1, 59);
        end_frame("f3", 1'b1, 1'b0, 1'b1, 1'b0);
        check_fields("f3", 8'h99, 5'h12, 6'h31, 6'h23, 7'h59, 1'b0, 1'b1);

        check("exclusive", both_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
